lc_mem_arbiter: RTL and testbench
=================================

Name: lc_mem_arbiter

Overview:
- Shares the single-port life-cycle value ROM between NUM_REQ requesters, e.g. the LC FSM, key derivation and debug unlock.
- Arbitrates round-robin, sequences one ROM read per grant, and routes the 256-bit result back to the winner.
- Out-of-range addresses are rejected without touching the ROM.
- Sits between the requesters and the ROM port: rd_en/addr out, rdData/valid in, 1-cycle read latency.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 256, ROM word width
LENGTH, 6, ROM depth; valid addresses 0..LENGTH-1
TIMEOUT, 8, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_i  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ x $clog2(LENGTH)  per-requester address, held with req_i until gnt
gnt  output  NUM_REQ  one-hot grant, single-cycle pulse
rsp_valid  output  NUM_REQ  one-hot response strobe, single-cycle pulse
rsp_data  output  WIDTH  response data, qualified by rsp_valid; 0 otherwise
rsp_err  output  1  response error flag, qualified by rsp_valid; 0 otherwise
busy  output  1  high whenever state != IDLE
mem_rd_en  output  1  ROM read enable
mem_addr  output  $clog2(LENGTH)  ROM address
mem_rdData  input  WIDTH  ROM read data
mem_valid  input  1  ROM data valid, one cycle after mem_rd_en

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, mem_rd_en=0, mem_addr=0.
  - state=IDLE; round-robin pointer=NUM_REQ-1, so requester 0 has highest priority first.
- Reset mid-operation aborts any transaction. The aborted requester receives no response.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_i high (edge 0):
  - Pick the first asserted requester k searching from pointer+1, wrapping modulo NUM_REQ.
  - Latch k and req_addr[k]; pointer<=k; gnt[k]<=1; go to ISSUE.
  - If addr<LENGTH: mem_rd_en<=1, mem_addr<=addr.
  - If addr>=LENGTH: set error flag; mem_rd_en stays 0.
- ISSUE (cycle 1): gnt[k]=1 and mem_rd_en=1 for exactly this cycle. Next edge: gnt<=0, mem_rd_en<=0, go to WAIT.
- WAIT (cycle 2):
  - On mem_valid: rsp_data<=mem_rdData, rsp_err<=0.
  - If the error flag is set, do not wait: rsp_data<=0, rsp_err<=1.
  - Either way: rsp_valid[k]<=1, go to RESP.
- RESP (cycle 3): rsp_valid[k]=1 for one cycle. Next edge: rsp_valid, rsp_data, rsp_err <=0; go to IDLE.
- Timing: req-to-gnt 1 cycle, req-to-rsp 3 cycles. New arbitration earliest in cycle 4; peak throughput 1 read per 4 cycles.
- req_i is sampled only in IDLE. A req_i still high on return to IDLE is a new request.
- Requesters drop req_i the cycle after seeing gnt.
- mem_valid outside WAIT is ignored.
- Simultaneous requests: exactly one grant per transaction; losers stay pending.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.

Optional Feature:
LC_ARB_TIMEOUT_EN
- Defined:
  - A counter ($clog2(TIMEOUT+1) bits) clears on WAIT entry and increments each WAIT cycle without mem_valid.
  - When it reaches TIMEOUT: respond with rsp_err=1, rsp_data=0, then go to RESP.
  - A late mem_valid after the timeout is ignored.
- Undefined: WAIT holds indefinitely until mem_valid arrives.

Decomposition:
- Package lc_arb_pkg:
  - Typedef lc_arb_state_e (IDLE, ISSUE, WAIT, RESP).
  - Constants LC_WIDTH=256, LC_LENGTH=6, LC_ADDR_W=$clog2(LC_LENGTH).
- Sub-module lc_rr_arbiter:
  - Inputs: NUM_REQ request vector, pointer.
  - Outputs: one-hot winner and its index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single read: req_i=4'b0001, req_addr[0]=1. Expect gnt[0] in cycle 1, mem_rd_en=1 with mem_addr=1 in cycle 1, rsp_valid[0] in cycle 3, rsp_data=33a344a3...ea56a24a, rsp_err=0.
- All four request at once, addresses 2,3,4,5. Expect grant order 0,1,2,3 on 4-cycle spacing, each requester gets the matching ROM word, and the pointer ends at 3.
- Out-of-range: requester 2 sends addr=6 or 7. Expect gnt[2], mem_rd_en stays 0, rsp_valid[2] at cycle 3 with rsp_err=1 and rsp_data=0.
- Fairness: requesters 0 and 1 hold req_i high continuously. Expect grants to alternate 0,1,0,1 and no starvation.
- Reset mid-WAIT: assert rst for 1 cycle. Expect all outputs 0, no rsp_valid, and the next request from requester 0 granted first.
- Timeout (macro defined): ROM model withholds mem_valid. Expect rsp_err=1 after 8 WAIT cycles. Then inject a late mem_valid and confirm it is ignored.

Source files
------------

// File: rtl/lc_arb_pkg.sv
// lc_arb_pkg: shared FSM state type and ROM geometry constants for the LC ROM arbiter
package lc_arb_pkg;
  localparam int LC_WIDTH = 256;
  localparam int LC_LENGTH = 6;
  localparam int LC_ADDR_W = $clog2(LC_LENGTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lc_arb_state_e;
endpackage

// File: rtl/lc_mem_arbiter_rr.sv
// lc_rr_arbiter: combinational round-robin pick; req vector + last-winner ptr in, one-hot winner + index out
module lc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IW-1:0]      idx
);
  always_comb begin
    logic found;
    int j;
    found = 1'b0;
    idx = '0;
    j = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx = IW'(j);
      end
    end
    winner = found ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/lc_mem_arbiter.sv
// lc_mem_arbiter: round-robin share of the LC value ROM; clk/rst, requester side req_i/req_addr/gnt/rsp_valid/rsp_data/rsp_err/busy, ROM side mem_rd_en/mem_addr/mem_rdData/mem_valid; LC_ARB_TIMEOUT_EN bounds the WAIT state
module lc_mem_arbiter
  import lc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = LC_WIDTH,
  parameter int LENGTH = LC_LENGTH,
  parameter int TIMEOUT = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_i,
  input  logic [NUM_REQ-1:0][$clog2(LENGTH)-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                       gnt,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  output logic [WIDTH-1:0]                         rsp_data,
  output logic                                     rsp_err,
  output logic                                     busy,
  output logic                                     mem_rd_en,
  output logic [$clog2(LENGTH)-1:0]                mem_addr,
  input  logic [WIDTH-1:0]                         mem_rdData,
  input  logic                                     mem_valid
);
  localparam int AW = $clog2(LENGTH);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("lc_mem_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
  end
  lc_arb_state_e state, state_d;
  logic [IW-1:0] ptr, ptr_d, idx, idx_d, win_idx;
  logic [NUM_REQ-1:0] win_oh, gnt_d, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_d;
  logic [AW-1:0] addr_d;
  logic err, err_d, rsp_err_d, rd_en_d, oor, ok, tmo;
  lc_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req    (req_i),
    .ptr    (ptr),
    .winner (win_oh),
    .idx    (win_idx)
  );
  assign oor = int'(req_addr[win_idx]) >= LENGTH;
  assign ok = !err && mem_valid;
`ifdef LC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) cnt <= '0;
    else if (!mem_valid) cnt <= cnt + 1'b1;
  end
  assign tmo = cnt == CW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    idx_d = idx;
    err_d = err;
    gnt_d = '0;
    rsp_valid_d = '0;
    rsp_data_d = '0;
    rsp_err_d = 1'b0;
    rd_en_d = 1'b0;
    addr_d = mem_addr;
    case (state)
      IDLE: if (|req_i) begin
        state_d = ISSUE;
        ptr_d = win_idx;
        idx_d = win_idx;
        gnt_d = win_oh;
        err_d = oor;
        rd_en_d = !oor;
        addr_d = oor ? mem_addr : req_addr[win_idx];
      end
      ISSUE: state_d = WAIT;
      WAIT: if (err || mem_valid || tmo) begin
        state_d = RESP;
        rsp_valid_d = NUM_REQ'(1) << idx;
        rsp_err_d = !ok;
        rsp_data_d = ok ? mem_rdData : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      idx <= '0;
      err <= 1'b0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      idx <= idx_d;
      err <= err_d;
      gnt <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_data <= rsp_data_d;
      rsp_err <= rsp_err_d;
      busy <= state_d != IDLE;
      mem_rd_en <= rd_en_d;
      mem_addr <= addr_d;
    end
  end
endmodule

// File: tb/tb_lc_mem_arbiter.sv
// tb_lc_mem_arbiter: randomized and directed stimulus against a transaction-level reference model
module tb_lc_mem_arbiter;
  localparam int N = 4, W = 256, L = 6, AW = 3, TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic [W-1:0] rsp_data, mem_rdData = '0;
  logic rsp_err, busy, mem_rd_en, mem_valid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [W-1:0] rom [8];
  logic withhold = 1'b0, inject = 1'b0, model_on = 1'b0;
  logic [N-1:0] hold = '0;
  int n_cmp = 0, n_err = 0;
  int t = 0, k = 0, last = N - 1;
  bit rst_seen = 1'b1;
  logic [AW-1:0] a = '0;
  int gcount [N] = '{default: 0};
  always #5 clk = ~clk;
  lc_mem_arbiter #(.NUM_REQ(N), .WIDTH(W), .LENGTH(L), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdData (mem_rdData),
    .mem_valid  (mem_valid)
  );
  always @(posedge clk) begin
    mem_valid <= (mem_rd_en && !withhold) || inject;
    mem_rdData <= mem_rd_en ? rom[mem_addr] : {8{$urandom}};
  end
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (model_on) begin
    logic inr;
    logic [W-1:0] ed;
    bit found;
    inr = int'(a) < L;
    ed = inr ? rom[a] : '0;
    case (t)
      0: begin
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
        chk("idle_rsp", rsp_valid, 0);
        chk("idle_rd_en", mem_rd_en, 0);
        chk("idle_data", rsp_data, 0);
        chk("idle_err", rsp_err, 0);
        if (rst_seen) chk("rst_addr", mem_addr, 0);
      end
      1: begin
        chk("gnt", gnt, 1 << k);
        chk("issue_busy", busy, 1);
        chk("issue_rd_en", mem_rd_en, inr);
        if (inr) chk("issue_addr", mem_addr, a);
        chk("issue_rsp", rsp_valid, 0);
      end
      2: begin
        chk("wait_gnt", gnt, 0);
        chk("wait_rd_en", mem_rd_en, 0);
        chk("wait_busy", busy, 1);
        chk("wait_rsp", rsp_valid, 0);
      end
      default: begin
        chk("rsp_valid", rsp_valid, 1 << k);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, !inr);
        chk("rsp_busy", busy, 1);
        chk("rsp_gnt", gnt, 0);
      end
    endcase
    rst_seen = 1'b0;
    for (int i = 0; i < N; i++) if (gnt[i]) gcount[i]++;
    if (rst) begin
      t = 0;
      last = N - 1;
      rst_seen = 1'b1;
    end else if (t == 0) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        if (!found && req_i[(last + i) % N]) begin
          found = 1'b1;
          k = (last + i) % N;
        end
      end
      if (found) begin
        a = req_addr[k];
        last = k;
        t = 1;
      end
    end else t = (t + 1) % 4;
  end
  task automatic step(input int n = 1, input bit rnd = 1'b0);
    repeat (n) begin
      @(posedge clk);
      #1;
      inject = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && !hold[i]) req_i[i] = 1'b0;
        if (rnd && !req_i[i] && $urandom_range(0, 3) == 0) begin
          req_i[i] = 1'b1;
          req_addr[i] = AW'($urandom_range(0, 7));
        end
      end
      if (rnd) inject = $urandom_range(0, 7) == 0;
    end
  endtask
  initial begin
    int base, d;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rom[i][32*j +: 32] = $urandom;
    rom[1][255:224] = 32'h33a344a3;
    rom[1][31:0] = 32'hea56a24a;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_on = 1'b1;
    req_addr[0] = 3'd1;
    req_i = 4'b0001;
    step(6);
    req_addr = {3'd5, 3'd4, 3'd3, 3'd2};
    req_i = 4'b1111;
    step(20);
    req_addr[2] = 3'd6;
    req_i = 4'b0100;
    step(6);
    req_addr[2] = 3'd7;
    req_i = 4'b0100;
    step(6);
    base = gcount[0] - gcount[1];
    hold = 4'b0011;
    req_addr[0] = 3'd0;
    req_addr[1] = 3'd4;
    req_i = 4'b0011;
    step(24);
    hold = '0;
    step(12);
    d = gcount[0] - gcount[1] - base;
    chk("fairness", d >= -1 && d <= 1, 1);
    req_addr[3] = 3'd0;
    req_i = 4'b1000;
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_addr = {3'd1, 3'd2, 3'd3, 3'd5};
    req_i = 4'b1111;
    step(20);
`ifdef LC_ARB_TIMEOUT_EN
    begin
      int c;
      model_on = 1'b0;
      withhold = 1'b1;
      req_addr[1] = 3'd0;
      req_i = 4'b0010;
      c = 0;
      while (rsp_valid == '0 && c < 40) begin
        step();
        c++;
      end
      chk("tmo_latency", c, TO + 2);
      chk("tmo_rsp", rsp_valid, 4'b0010);
      chk("tmo_err", rsp_err, 1);
      chk("tmo_data", rsp_data, 0);
      inject = 1'b1;
      step(4);
      chk("late_rsp", rsp_valid, 0);
      chk("late_busy", busy, 0);
      withhold = 1'b0;
      t = 0;
      last = 1;
      model_on = 1'b1;
    end
`endif
    step(400, 1'b1);
    step(40);
    model_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
